// File: rtl/rv_muldiv_pkg.sv
// Shared RV32M constants: funct3 codes, M-extension funct7 and the
// multiply/divide unit's state encoding.
package rv_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_M  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide for the EX stage: 32 shift-add or restoring
// steps on magnitudes, followed by a sign-fix cycle; stalls the front end meanwhile.
module ex_muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  muldiv_state_e state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic        done_q, done_d;

  logic        is_div;
  logic [32:0] add_x, add_y;
  logic [33:0] sum;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix, res_fix;
  logic        sa_in, sb_in;
  logic [31:0] mag_a, mag_b;

  // acc holds {hi, multiplier} for multiply and {rem, quot} for divide;
  // opnd is the multiplicand or the divisor magnitude.
  assign is_div = f3_q[2];
  assign add_x  = is_div ? acc_q[63:31] : {1'b0, acc_q[63:32]};
  assign add_y  = is_div ? ~{1'b0, opnd_q} : (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign sum    = {1'b0, add_x} + {1'b0, add_y} + {33'd0, is_div};

  assign prod_fix = (sa_q ^ sb_q) ? (64'd0 - acc_q) : acc_q;
  assign quot_fix = (sa_q ^ sb_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix  = sa_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  assign sa_in = a[31] & (funct3 == F3_MULH || funct3 == F3_MULHSU ||
                          funct3 == F3_DIV  || funct3 == F3_REM);
  assign sb_in = b[31] & (funct3 == F3_MULH || funct3 == F3_DIV || funct3 == F3_REM);
  assign mag_a = sa_in ? (32'd0 - a) : a;
  assign mag_b = sb_in ? (32'd0 - b) : b;

  always_comb begin
    res_fix = quot_fix;
    case (f3_q)
      F3_MUL:                        res_fix = prod_fix[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  res_fix = prod_fix[63:32];
      F3_REM, F3_REMU:               res_fix = rem_fix;
      default:                       res_fix = quot_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          f3_d    = funct3;
          rd_d    = rd_in;
          sa_d    = sa_in;
          sb_d    = sb_in;
          cnt_d   = 6'd0;
          state_d = CALC;
          if (funct3[2]) begin
            opnd_d = mag_b;
            acc_d  = {32'd0, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {32'd0, mag_b};
          end
          if (funct3[2] && b == 32'd0) begin
            state_d  = DONE;
            done_d   = 1'b1;
            rd_out_d = rd_in;
            result_d = funct3[1] ? a : 32'hFFFF_FFFF;
          end else if ((funct3 == F3_DIV || funct3 == F3_REM) &&
                       a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            state_d  = DONE;
            done_d   = 1'b1;
            rd_out_d = rd_in;
            result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (is_div)
          acc_d = sum[33] ? {sum[31:0], acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
        else
          acc_d = {sum[32:0], acc_q[31:1]};
        if (cnt_q == 6'd31)
          state_d = FIX;
      end
      FIX: begin
        state_d  = DONE;
        done_d   = 1'b1;
        result_d = res_fix;
        rd_out_d = rd_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      f3_q     <= 3'd0;
      rd_q     <= 5'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

  assign stall  = (state_q == IDLE && start && !flush) || state_q == CALC || state_q == FIX;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: RV32M reference model in 64-bit
// arithmetic, directed plan cases, random operations, flush and reset aborts.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_exp = 32'd0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .a(a), .b(b), .rd_in(rd_in), .flush(flush),
    .stall(stall), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M semantics, including divide-by-zero and signed overflow.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    longint          xs, ys, p, q;
    longint unsigned xu, yu, pu;
    logic [31:0]     r;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    xu = {32'd0, x};
    yu = {32'd0, y};
    r  = 32'd0;
    case (f3)
      3'b000: begin p = xs * ys; r = p[31:0]; end
      3'b001: begin p = xs * ys; r = p[63:32]; end
      3'b010: begin p = xs * longint'(yu); r = p[63:32]; end
      3'b011: begin pu = xu * yu; r = pu[63:32]; end
      3'b100: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin q = xs / ys; r = q[31:0]; end
      end
      3'b101: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else begin pu = xu / yu; r = pu[31:0]; end
      end
      3'b110: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
        else begin q = xs % ys; r = q[31:0]; end
      end
      default: begin
        if (y == 0) r = x;
        else begin pu = xu % yu; r = pu[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    if (f3[2] && y == 0) return 1'b1;
    if ((f3 == 3'b100 || f3 == 3'b110) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: begin
        v = 32'($urandom_range(0, 20));
        if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issues one instruction, holding start while stalled as ID/EX would,
  // and checks latency and stall length; result/rd go through the scoreboard.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y, input logic [4:0] rd);
    exp_t e;
    int   lat, stalls, exp_lat;
    bit   got;
    @(negedge clk);
    start  = 1'b1;
    funct3 = f3;
    a      = x;
    b      = y;
    rd_in  = rd;
    e.res  = ref_result(f3, x, y);
    e.rd   = rd;
    sb_q.push_back(e);
    last_exp = e.res;
    exp_lat  = is_special(f3, x, y) ? 1 : 34;
    lat = 0;
    stalls = 0;
    got = 1'b0;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (stall) stalls++;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    if (!got) checkOutput("done_timeout", 32'(got), 32'd1);
    else begin
      checkOutput("latency", 32'(lat), 32'(exp_lat));
      checkOutput("stall_cycles", 32'(stalls), 32'(exp_lat));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      if (sb_q.size() == 0) begin
        checkOutput("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
      end
    end
  end

  initial begin
    logic [2:0] rf3;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_rd_out", {27'd0, rd_out}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(3'b000, 32'hFFFF_FFFE, 32'd3, 5'd5);
    applyStimulus(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
    applyStimulus(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9);
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10);
    applyStimulus(3'b101, 32'd7, 32'd2, 5'd11);
    applyStimulus(3'b111, 32'd7, 32'd2, 5'd12);
    applyStimulus(3'b100, 32'h0000_1234, 32'd0, 5'd13);
    applyStimulus(3'b110, 32'h0000_1234, 32'd0, 5'd14);
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    applyStimulus(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);

    // Flush a DIV during its tenth cycle; nothing may complete.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; a = 32'd100; b = 32'd7; rd_in = 5'd20;
    repeat (10) @(negedge clk);
    start = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush_stall", {31'd0, stall}, 32'd0);
    checkOutput("flush_done", {31'd0, done}, 32'd0);
    checkOutput("flush_result_held", result, last_exp);
    repeat (40) @(negedge clk);
    applyStimulus(3'b000, 32'd1234, 32'hFFFF_FF00, 5'd21);

    for (int i = 0; i < 60; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      applyStimulus(rf3, pick_operand(), pick_operand(), 5'($urandom_range(1, 31)));
    end

    // Reset in the middle of a multiply discards it at once.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; a = 32'd99; b = 32'd77; rd_in = 5'd30;
    repeat (8) @(negedge clk);
    #2;
    start = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("midreset_result", result, 32'd0);
    checkOutput("midreset_rd_out", {27'd0, rd_out}, 32'd0);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_stall", {31'd0, stall}, 32'd0);
    last_exp = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(3'b111, 32'hDEAD_BEEF, 32'd1000, 5'd3);
    applyStimulus(3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd4);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
